// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Owns the program counter and the hardware return stack. Each cycle it
//   presents pc to the synchronous program memory. Redirects from the
//   execute stage (GOTO, CALL, RETURN family, computed goto via PCL) flush
//   the wrong-path fetch and load the new target.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   stall             hold pc/instr_pc/stack, no fetch, redirects ignored
//   goto_req          jump to {pclath[4:3], branch_addr}
//   call_req          push pc, jump to {pclath[4:3], branch_addr}
//   ret_req           pop the return stack and jump to the popped address
//   pcl_wr            jump to {pclath[4:0], pcl_data}
//   branch_addr       11-bit literal from GOTO/CALL
//   pcl_data          value written to PCL
//   pclath            PCLATH<4:0>
//   mem_addr          program memory address (= pc)
//   mem_rd_en         program memory read enable
//   mem_flush         turns the fetch of this cycle into a NOP
//   instr_pc          address of the instruction now on the memory output
//   stack_ovf         sticky, set by a push while the stack is full
//   stack_unf         sticky, set by a pop while the stack is empty
module fetch_sequencer #(
   parameter int unsigned ADDR_WIDTH  = 13,
   parameter int unsigned STACK_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall,
   input  logic                  goto_req,
   input  logic                  call_req,
   input  logic                  ret_req,
   input  logic                  pcl_wr,
   input  logic [10:0]           branch_addr,
   input  logic [7:0]            pcl_data,
   input  logic [4:0]            pclath,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_rd_en,
   output logic                  mem_flush,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   output logic                  stack_ovf,
   output logic                  stack_unf
);

   localparam int unsigned SP_W  = $clog2(STACK_DEPTH);
   localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STACK_DEPTH);

   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
   logic [SP_W-1:0]       sp_q, sp_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;
   logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];
   logic [ADDR_WIDTH-1:0] stack_d [STACK_DEPTH];

   logic                  active;
   logic                  redirect;
   logic [SP_W-1:0]       sp_dec;
   logic [ADDR_WIDTH-1:0] jump_target;
   logic [ADDR_WIDTH-1:0] pcl_target;

   assign active      = rst_n & ~stall;
   assign redirect    = ret_req | call_req | goto_req | pcl_wr;
   assign sp_dec      = sp_q - 1'b1;
   assign jump_target = ADDR_WIDTH'({pclath[4:3], branch_addr});
   assign pcl_target  = ADDR_WIDTH'({pclath, pcl_data});

   always_comb begin
      pc_d       = pc_q;
      instr_pc_d = instr_pc_q;
      sp_d       = sp_q;
      count_d    = count_q;
      ovf_d      = ovf_q;
      unf_d      = unf_q;
      stack_d    = stack_q;

      if (!stall) begin
         instr_pc_d = pc_q;
         pc_d       = pc_q + 1'b1;
         // Priority chain: the first matching request wins, the rest drop.
         if (ret_req) begin
            pc_d = stack_q[sp_dec];
            sp_d = sp_dec;
            if (count_q == '0) begin
               unf_d = 1'b1;
            end else begin
               count_d = count_q - 1'b1;
            end
         end else if (call_req) begin
            pc_d          = jump_target;
            stack_d[sp_q] = pc_q;
            sp_d          = sp_q + 1'b1;
            // When full, the push lands on the oldest entry (circular buffer).
            if (count_q == CNT_FULL) begin
               ovf_d = 1'b1;
            end else begin
               count_d = count_q + 1'b1;
            end
         end else if (goto_req) begin
            pc_d = jump_target;
         end else if (pcl_wr) begin
            pc_d = pcl_target;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= '0;
         instr_pc_q <= '0;
         sp_q       <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
         for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
            stack_q[i] <= '0;
         end
      end else begin
         pc_q       <= pc_d;
         instr_pc_q <= instr_pc_d;
         sp_q       <= sp_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
         stack_q    <= stack_d;
      end
   end

   assign mem_addr  = pc_q;
   assign mem_rd_en = active;
   assign mem_flush = active & redirect;
   assign instr_pc  = instr_pc_q;
   assign stack_ovf = ovf_q;
   assign stack_unf = unf_q;

endmodule
